// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction-memory loader.
//   - default geometry (byte-address width, instruction width)
//   - bytes per instruction word
//   - loader FSM state type
package imem_pkg;

  localparam int INS_ADDRESS_DEF = 9;
  localparam int INS_W_DEF       = 32;
  localparam int BYTES_PER_WORD  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and memory write port of the loader.
//   s_valid/s_data/s_ready : byte stream with valid/ready handshake
//   imem_we/imem_wa/imem_wd : word-aligned write port into instruction memory
// Modports:
//   slave  - the loader (consumes bytes, drives the write port)
//   master - the environment (sources bytes, observes the write port)
interface imem_loader_if
  import imem_pkg::*;
#(
  parameter int INS_ADDRESS = INS_ADDRESS_DEF,
  parameter int INS_W       = INS_W_DEF
);

  logic                   s_valid;
  logic [7:0]             s_data;
  logic                   s_ready;
  logic                   imem_we;
  logic [INS_ADDRESS-1:0] imem_wa;
  logic [INS_W-1:0]       imem_wd;

  modport slave (
    input  s_valid, s_data,
    output s_ready, imem_we, imem_wa, imem_wd
  );

  modport master (
    output s_valid, s_data,
    input  s_ready, imem_we, imem_wa, imem_wd
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: collects four stream bytes into one little-endian word.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - discard any partial word and restart at byte 0
//   accept      - a byte is taken this cycle
//   byte_in     - the byte being taken
//   word_next   - assembly contents with the current byte already inserted;
//                 equals the complete word in the cycle word_full is high
//   word_full   - the byte taken this cycle completes a word
module word_assembler
  import imem_pkg::*;
#(
  parameter int INS_W = INS_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             accept,
  input  logic [7:0]       byte_in,
  output logic [INS_W-1:0] word_next,
  output logic             word_full
);

  logic [1:0]       byte_idx_reg;
  logic [INS_W-1:0] asm_reg;

  // Byte k lands in bits [8k+7:8k], so the first byte is the LSB.
  generate
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      assign word_next[8*gi +: 8] = (accept && byte_idx_reg == 2'(gi)) ? byte_in
                                                                        : asm_reg[8*gi +: 8];
    end
  endgenerate

  assign word_full = accept && (byte_idx_reg == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx_reg <= 2'd0;
      asm_reg      <= '0;
    end else if (clr) begin
      byte_idx_reg <= 2'd0;
      asm_reg      <= '0;
    end else if (accept) begin
      // The 2-bit index wraps to 0 after the 4th byte by itself.
      byte_idx_reg <= byte_idx_reg + 2'd1;
      asm_reg      <= word_full ? '0 : word_next;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
// Receives a program as a byte stream, assembles little-endian 32-bit words
// and writes them to consecutive word addresses starting at 0. The core is
// held in reset (cpu_hold) for the whole load so fetch never sees a
// partially written memory.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - one-cycle pulse beginning a load (only honoured in IDLE)
//   load_len   - number of words to load, latched on an accepted start
//   bus        - byte stream in and memory write port out (slave modport)
//   busy       - load in progress (RECV, WRITE, DONE)
//   done       - one-cycle pulse after the last word is written
//   err        - one-cycle pulse when a start carries an illegal length
//   cpu_hold   - keeps the core in reset while a load is in progress
module imem_loader
  import imem_pkg::*;
#(
  parameter int INS_ADDRESS = INS_ADDRESS_DEF,
  parameter int INS_W       = INS_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [INS_ADDRESS-2:0] load_len,
  imem_loader_if.slave           bus,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   cpu_hold
);

  localparam int DEPTH = 2 ** (INS_ADDRESS - 2);
  localparam int LEN_W = INS_ADDRESS - 1;
  localparam int IDX_W = INS_ADDRESS - 2;

  // Four bytes form one word; any other width cannot be assembled.
  generate
    if (INS_W != 32) begin : g_bad_width
      $error("imem_loader: INS_W must be 32");
    end
  endgenerate

  loader_state_t    state_reg, state_next;
  logic [LEN_W-1:0] len_reg;
  logic [IDX_W-1:0] word_idx_reg;
  logic [INS_ADDRESS-1:0] wa_reg;
  logic [INS_W-1:0] wd_reg;
  logic             err_reg, err_next;

  logic             len_ok;
  logic             start_ok;
  logic             accept;
  logic             last_word;
  logic [INS_W-1:0] word_next;
  logic             word_full;

  assign len_ok    = (load_len != '0) && (int'(load_len) <= DEPTH);
  assign start_ok  = (state_reg == IDLE) && start && len_ok;
  assign accept    = (state_reg == RECV) && bus.s_valid;
  assign last_word = (LEN_W'(word_idx_reg) == (len_reg - LEN_W'(1)));

  word_assembler #(.INS_W(INS_W)) u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start_ok),
    .accept   (accept),
    .byte_in  (bus.s_data),
    .word_next(word_next),
    .word_full(word_full)
  );

  // Next-state and error-pulse logic.
  always_comb begin
    state_next = state_reg;
    err_next   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          if (len_ok) state_next = RECV;
          else        err_next   = 1'b1;
        end
      end
      RECV:  if (word_full) state_next = WRITE;
      WRITE: state_next = last_word ? DONE : RECV;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      len_reg      <= '0;
      word_idx_reg <= '0;
      wa_reg       <= '0;
      wd_reg       <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
      if (start_ok) begin
        len_reg      <= load_len;
        word_idx_reg <= '0;
      end
      // Capture address and data as the word completes, so both are
      // registered and stable for the single WRITE cycle.
      if (state_reg == RECV && word_full) begin
        wa_reg <= {word_idx_reg, 2'b00};
        wd_reg <= word_next;
      end
      if (state_reg == WRITE && !last_word) begin
        word_idx_reg <= word_idx_reg + IDX_W'(1);
      end
    end
  end

  assign bus.s_ready = (state_reg == RECV);
  assign bus.imem_we = (state_reg == WRITE);
  assign bus.imem_wa = wa_reg;
  assign bus.imem_wd = wd_reg;
  assign busy        = (state_reg != IDLE);
  assign cpu_hold    = (state_reg != IDLE);
  assign done        = (state_reg == DONE);
  assign err         = err_reg;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int INS_ADDRESS = 9;
  localparam int INS_W       = 32;
  localparam int DEPTH       = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [INS_ADDRESS-2:0] load_len = '0;
  logic busy, done, err, cpu_hold;

  imem_loader_if #(.INS_ADDRESS(INS_ADDRESS), .INS_W(INS_W)) bus ();

  imem_loader #(.INS_ADDRESS(INS_ADDRESS), .INS_W(INS_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .load_len(load_len),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [INS_ADDRESS-1:0] wa;
    logic [INS_W-1:0]       wd;
  } wr_t;
  wr_t exp_q[$];

  int wr_count = 0;
  int done_count = 0;
  int err_count = 0;
  logic prev_we = 1'b0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected writes and checks protocol relations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.imem_we) begin
        wr_t e;
        wr_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual wa=%0h wd=%0h required no write",
                   bus.imem_wa, bus.imem_wd);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", 64'(bus.imem_wa), 64'(e.wa));
          chk("write_data", 64'(bus.imem_wd), 64'(e.wd));
        end
        chk("ready_low_in_write", 64'(bus.s_ready), 64'd0);
        chk("hold_in_write", 64'(cpu_hold), 64'd1);
      end
      if (done) begin
        done_count++;
        chk("done_after_write", 64'(prev_we), 64'd1);
      end
      if (prev_done) chk("hold_busy_drop_after_done", {62'd0, busy, cpu_hold}, 64'd0);
      if (err) err_count++;
      prev_we   = bus.imem_we;
      prev_done = done;
    end else begin
      prev_we   = 1'b0;
      prev_done = 1'b0;
    end
  end

  // Reference model: word i of a stream is bytes 4i..4i+3, little-endian, at byte address 4i.
  task automatic expect_words(input logic [7:0] b[$], input int n);
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.wa = INS_ADDRESS'(i * 4);
      e.wd = {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
      exp_q.push_back(e);
    end
  endtask

  // All tasks start and end at #1 after a rising edge.
  task automatic start_pulse(input logic [7:0] len);
    start = 1'b1;
    load_len = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int guard;
    while ($urandom_range(0, 99) < gap_pct) begin
      bus.s_valid = 1'b0;
      @(posedge clk); #1;
    end
    guard = 0;
    while (!bus.s_ready && guard < 50) begin
      bus.s_valid = (gap_pct > 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.s_data  = 8'($urandom);
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) chk("ready_timeout", 64'(bus.s_ready), 64'd1);
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    @(posedge clk); #1;
  endtask

  task automatic send_stream(input logic [7:0] b[$], input int gap_pct);
    foreach (b[i]) send_byte(b[i], gap_pct);
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int c = 0;
    while (done_count < target && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    chk("done_seen", 64'(done_count >= target), 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_load(input string name, input logic [7:0] b[$], input int n, input int gap_pct);
    int w0, d0, e0;
    w0 = wr_count; d0 = done_count; e0 = err_count;
    expect_words(b, n);
    start_pulse(8'(n));
    send_stream(b, gap_pct);
    wait_done(d0 + 1, 8 * n + 100);
    chk({name, "_writes"}, 64'(wr_count - w0), 64'(n));
    chk({name, "_dones"}, 64'(done_count - d0), 64'd1);
    chk({name, "_errs"}, 64'(err_count - e0), 64'd0);
    chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    $display("load %s len=%0d gap=%0d writes=%0d", name, n, gap_pct, wr_count - w0);
  endtask

  task automatic bad_len(input logic [7:0] len);
    int w0;
    w0 = wr_count;
    start_pulse(len);
    chk("err_pulse", 64'(err), 64'd1);
    chk("err_busy", 64'(busy), 64'd0);
    chk("err_hold", 64'(cpu_hold), 64'd0);
    @(posedge clk); #1;
    chk("err_one_cycle", 64'(err), 64'd0);
    chk("err_still_idle", {62'd0, busy, bus.s_ready}, 64'd0);
    chk("err_no_write", 64'(wr_count - w0), 64'd0);
    $display("bad start len=%0d err seen", len);
  endtask

  initial begin
    logic [7:0] basic[$];
    logic [7:0] b[$];
    int n, w0, d0, e0;

    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    #2;
    chk("reset_flags", {60'd0, busy, done, err, cpu_hold}, 64'd0);
    chk("reset_port", {61'd0, bus.s_ready, bus.imem_we, 1'b0}, 64'd0);
    chk("reset_wa_wd", {23'd0, bus.imem_wa, bus.imem_wd}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    basic = '{8'h33, 8'h70, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load("basic", basic, 2, 0);
    run_load("gaps", basic, 2, 40);

    bad_len(8'd0);
    bad_len(8'd129);

    for (int t = 0; t < 4; t++) begin
      n = $urandom_range(1, 6);
      b.delete();
      for (int i = 0; i < 4 * n; i++) b.push_back(8'($urandom));
      run_load("random", b, n, 30);
    end

    b.delete();
    for (int i = 0; i < DEPTH; i++) repeat (4) b.push_back(8'(i));
    run_load("full_depth", b, DEPTH, 0);

    // Reset after 6 of 8 bytes: only the first word may have been written.
    w0 = wr_count;
    expect_words(basic, 2);
    start_pulse(8'd2);
    b = basic;
    b = b[0:5];
    send_stream(b, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_flags", {60'd0, busy, done, err, cpu_hold}, 64'd0);
    chk("midreset_port", {62'd0, bus.s_ready, bus.imem_we}, 64'd0);
    chk("midreset_wa_wd", {23'd0, bus.imem_wa, bus.imem_wd}, 64'd0);
    chk("midreset_writes", 64'(wr_count - w0), 64'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset mid-load writes_before_reset=%0d", wr_count - w0);
    b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load("after_reset", b, 1, 0);

    // A start while busy must be ignored.
    w0 = wr_count; d0 = done_count; e0 = err_count;
    expect_words(basic, 2);
    start_pulse(8'd2);
    fork
      send_stream(basic, 20);
      begin
        repeat (3) @(posedge clk);
        #2;
        start = 1'b1;
        load_len = 8'd5;
        @(posedge clk); #2;
        start = 1'b0;
      end
    join
    wait_done(d0 + 1, 200);
    repeat (10) @(posedge clk);
    #1;
    chk("busy_start_writes", 64'(wr_count - w0), 64'd2);
    chk("busy_start_dones", 64'(done_count - d0), 64'd1);
    chk("busy_start_errs", 64'(err_count - e0), 64'd0);
    chk("busy_start_idle", {62'd0, busy, cpu_hold}, 64'd0);
    chk("busy_start_queue", 64'(exp_q.size()), 64'd0);
    $display("start while busy writes=%0d", wr_count - w0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
